// File: rtl/debounce_switch.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | debounce_switch: two-flop synchroniser plus stability counter; output     |
// | follows the input only after DEBOUNCE_LIMIT stable cycles.                |
// | Optional DEBOUNCE_SWITCH_EDGE_EN adds o_Rise/o_Fall.  Rev 1.0             |
// +--------------------------------------------------------------------------+
module debounce_switch #(
  parameter int DEBOUNCE_LIMIT = 250000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_Switch,
  output logic o_Switch
`ifdef DEBOUNCE_SWITCH_EDGE_EN
  ,
  output logic o_Rise,
  output logic o_Fall
`endif
);

  localparam int COUNT_W = $clog2(DEBOUNCE_LIMIT);
  localparam logic [COUNT_W-1:0] COUNT_MAX = COUNT_W'(DEBOUNCE_LIMIT - 1);

  logic               sync1;
  logic               sync2;
  logic [COUNT_W-1:0] count;
  logic               accept;

  assign accept = (sync2 != o_Switch) && (count == COUNT_MAX);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      count    <= '0;
      o_Switch <= 1'b0;
    end else begin
      sync1 <= i_Switch;
      sync2 <= sync1;
      // Any cycle that agrees with the current output discards all progress.
      if (sync2 == o_Switch) begin
        count <= '0;
      end else if (accept) begin
        o_Switch <= sync2;
        count    <= '0;
      end else begin
        count <= count + COUNT_W'(1);
      end
    end
  end

`ifdef DEBOUNCE_SWITCH_EDGE_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      o_Rise <= 1'b0;
      o_Fall <= 1'b0;
    end else begin
      o_Rise <= accept & sync2;
      o_Fall <= accept & ~sync2;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_debounce_switch.sv
`default_nettype none
// Bench for debounce_switch with DEBOUNCE_LIMIT = 4: per-cycle expectations
// are queued when stimulus is applied and retired by a negedge monitor.
module tb_debounce_switch;

  localparam int LIMIT = 4;

  logic clk = 1'b0;
  logic reset_n;
  logic i_Switch;
  logic o_Switch;
`ifdef DEBOUNCE_SWITCH_EDGE_EN
  logic o_Rise;
  logic o_Fall;
`endif

  debounce_switch #(.DEBOUNCE_LIMIT(LIMIT)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_Switch (i_Switch),
    .o_Switch (o_Switch)
`ifdef DEBOUNCE_SWITCH_EDGE_EN
    ,
    .o_Rise   (o_Rise),
    .o_Fall   (o_Fall)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int   at;
    logic sw;
    logic rise;
    logic fall;
  } ent_t;

  ent_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  logic prev  = 1'b0;

  task automatic chk(input string tag, input logic obs, input logic expv);
    total++;
    if (obs !== expv) begin
      bad++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  task automatic exp_at(input int at, input logic sw, input logic r, input logic f);
    ent_t e;
    e.at = at; e.sw = sw; e.rise = r; e.fall = f;
    sb.push_back(e);
  endtask

  // k is the edge at which sync1 first captures the new level.
  task automatic exp_change(input int k, input logic newv);
    for (int i = 0; i < LIMIT + 1; i++) exp_at(k + i, ~newv, 1'b0, 1'b0);
    exp_at(k + LIMIT + 1, newv, newv, ~newv);
    exp_at(k + LIMIT + 2, newv, 1'b0, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && sb.size() > 0; i++) @(negedge clk);
    #1;
    chk("drain", sb.size() == 0, 1'b1);
    sb.delete();
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    ent_t e;
    if (!reset_n) begin
      prev = o_Switch;
    end else begin
      if (sb.size() > 0 && sb[0].at == cyc) begin
        e = sb.pop_front();
        chk("sw", o_Switch, e.sw);
`ifdef DEBOUNCE_SWITCH_EDGE_EN
        chk("rise", o_Rise, e.rise);
        chk("fall", o_Fall, e.fall);
`endif
      end else begin
        chk("unexp_change", o_Switch, prev);
`ifdef DEBOUNCE_SWITCH_EDGE_EN
        chk("unexp_rise", o_Rise, 1'b0);
        chk("unexp_fall", o_Fall, 1'b0);
`endif
      end
      prev = o_Switch;
    end
  end

  initial begin
    int c;
    reset_n  = 1'b0;
    i_Switch = 1'b1;
    #1;
    chk("rst_sw", o_Switch, 1'b0);
`ifdef DEBOUNCE_SWITCH_EDGE_EN
    chk("rst_rise", o_Rise, 1'b0);
    chk("rst_fall", o_Fall, 1'b0);
`endif
    repeat (2) @(negedge clk);
    i_Switch = 1'b0;
    repeat (2) @(negedge clk);
    #1 reset_n = 1'b1;
    repeat (3) @(negedge clk);

    // Clean press
    @(negedge clk); c = cyc; i_Switch = 1'b1;
    exp_change(c + 1, 1'b1);
    drain();

    // Clean release
    @(negedge clk); c = cyc; i_Switch = 1'b0;
    exp_change(c + 1, 1'b0);
    drain();

    // Single-cycle glitch must never reach the output
    @(negedge clk); c = cyc; i_Switch = 1'b1;
    for (int i = 1; i <= 20; i++) exp_at(c + i, 1'b0, 1'b0, 1'b0);
    @(negedge clk); i_Switch = 1'b0;
    drain();

    // Bounce: 3 high, 1 low, then held high
    @(negedge clk); c = cyc; i_Switch = 1'b1;
    for (int i = 1; i <= 4; i++) exp_at(c + i, 1'b0, 1'b0, 1'b0);
    exp_change(c + 5, 1'b1);
    repeat (3) @(negedge clk); i_Switch = 1'b0;
    @(negedge clk); i_Switch = 1'b1;
    drain();

    // Asynchronous reset while output high, input held high through release
    @(negedge clk); c = cyc;
    #1 reset_n = 1'b0;
    #1 chk("async_rst_sw", o_Switch, 1'b0);
    repeat (2) @(negedge clk);
    #1 reset_n = 1'b1;
    exp_change(c + 3, 1'b1);
    drain();

    // Release back to 0
    @(negedge clk); c = cyc; i_Switch = 1'b0;
    exp_change(c + 1, 1'b0);
    drain();

    // Reset mid-count aborts pending rise; count restarts after release
    @(negedge clk); c = cyc; i_Switch = 1'b1;
    repeat (3) @(negedge clk);
    #1 reset_n = 1'b0;
    #1 chk("midcount_rst_sw", o_Switch, 1'b0);
    @(negedge clk);
    #1 reset_n = 1'b1;
    exp_change(c + 5, 1'b1);
    drain();

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/debounce_switch.md
# debounce_switch

Single-input switch debouncer for mechanical push-buttons. It synchronises the raw pad signal into the `clk` domain and accepts a new level only after the level has been stable for a parameterised number of cycles. It then presents a clean, glitch-free level to game logic such as the frog movement controller, which performs its own edge detection. One instance is placed per physical switch.

## Interface
- `DEBOUNCE_LIMIT`, default 250000: number of consecutive stable cycles required before the output changes. 250000 equals 10 ms at the 25 MHz board clock. Legal range is ≥ 2.
- `clk` input 1: system clock. All state updates on the rising edge.
- `reset_n` input 1: reset, asynchronous, active-low. Clears all state immediately. Release is expected to be synchronous to `clk`.
- `i_Switch` input 1: raw switch level. Asynchronous to `clk` and may bounce.
- `o_Switch` output 1: debounced level, registered.
- `o_Rise` output 1: one-cycle pulse when `o_Switch` goes 0→1. Present only with `DEBOUNCE_SWITCH_EDGE_EN`.
- `o_Fall` output 1: one-cycle pulse when `o_Switch` goes 1→0. Present only with `DEBOUNCE_SWITCH_EDGE_EN`.

## Operation
- Synchroniser: two flip-flops, `sync1 <= i_Switch` and `sync2 <= sync1`. Only `sync2` is used downstream.
- Stability counter: width `$clog2(DEBOUNCE_LIMIT)` bits, unsigned. It never exceeds `DEBOUNCE_LIMIT-1`, so there is no wrap-around.
- On each rising edge, the first matching rule applies:
  - If `sync2 == o_Switch`, the counter is cleared to 0.
  - Else if `count < DEBOUNCE_LIMIT-1`, the counter is incremented.
  - Else (`count == DEBOUNCE_LIMIT-1`), `o_Switch <= sync2` and the counter is cleared to 0.
- A bounce, meaning `sync2` returning to `o_Switch` for even one cycle, restarts the count from 0. No partial credit is kept.
- The design has no FSM beyond the one-bit state `o_Switch` plus the counter.
- Output behaviour is symmetric for press and release.
- Reset values while `reset_n` = 0: `sync1` = 0, `sync2` = 0, counter = 0, `o_Switch` = 0, `o_Rise` = 0, `o_Fall` = 0.
- Reset asserted mid-count aborts the pending transition. After release, counting starts from zero.
- If `i_Switch` is 1 when reset is released, `o_Switch` rises after the full latency. With the edge feature enabled, this also produces an `o_Rise` pulse.

## Timing
- Take edge k as the first rising edge at which `sync1` captures a new stable level. Then:
  - `sync2` updates at edge k+1.
  - The first counting edge is k+2.
  - `o_Switch` updates at edge k+DEBOUNCE_LIMIT+1, which is the DEBOUNCE_LIMIT-th consecutive differing edge.
- Total latency is DEBOUNCE_LIMIT+1 cycles from first capture. The output is glitch-free because it is a direct register output.
- Minimum accepted pulse width is DEBOUNCE_LIMIT cycles of stable `sync2`. Shorter pulses never reach `o_Switch`.
- `o_Rise` and `o_Fall` are registered and asserted at the same edge that changes `o_Switch`. They deassert at the next edge.

## Configuration
- `DEBOUNCE_SWITCH_EDGE_EN`:
  - Defined: ports `o_Rise` and `o_Fall` exist, with the pulse behaviour above.
  - Undefined: the ports and their logic are absent, and only `o_Switch` is produced.
- `o_Switch` behaviour is identical in both builds.

## Test plan
All scenarios use `DEBOUNCE_LIMIT` = 4.
- Reset: hold `reset_n` = 0 with `i_Switch` = 1 → `o_Switch` = 0 and pulses = 0, immediately and without waiting for a clock edge.
- Clean press: `i_Switch` 0→1 before edge k, held → `o_Switch` = 1 exactly at edge k+5, and not at k+4. `o_Rise` = 1 for the single cycle after edge k+5.
- Bounce: `i_Switch` high 3 cycles, low 1 cycle, then high and held → `o_Switch` stays 0 through the first burst. It rises exactly 5 edges after the final 0→1 capture.
- Short glitch: a single-cycle pulse of 1 on `i_Switch` → `o_Switch` stays 0 for 20 cycles, with no `o_Rise` or `o_Fall`.
- Release: with `o_Switch` = 1, drop `i_Switch` to 0 and hold → `o_Switch` = 0 at edge k+5, with a single-cycle `o_Fall`.
- Reset mid-count: `i_Switch` = 1 for 3 cycles, pulse `reset_n` low, keep `i_Switch` = 1 → `o_Switch` rises 5 edges after the first post-reset capture edge.
